// File: rtl/hazard_control_unit_if.sv
// Hazard control bundle: hazard/miss inputs from the pipeline and the
// per-stage stall/flush and PC redirect outputs produced by the hazard unit.
// master = the hazard_control_unit, slave = the pipeline side.
interface hazard_control_unit_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      i_ic_miss;
    logic                      i_dc_miss;
    logic                      i_ex_valid;
    logic                      i_ex_is_load;
    logic [REG_ADDR_WIDTH-1:0] i_ex_rw_addr;
    logic                      i_dec_uses_rs;
    logic [REG_ADDR_WIDTH-1:0] i_dec_rs_addr;
    logic                      i_dec_uses_rt;
    logic [REG_ADDR_WIDTH-1:0] i_dec_rt_addr;
    logic                      i_ex_mispredict;
    logic [ADDR_WIDTH-1:0]     i_ex_recovery_target;

    logic                      o_pc_stall;
    logic                      o_pc_flush;
    logic                      o_i2d_stall;
    logic                      o_i2d_flush;
    logic                      o_d2e_stall;
    logic                      o_d2e_flush;
    logic                      o_e2m_stall;
    logic                      o_e2m_flush;
    logic                      o_m2w_stall;
    logic                      o_m2w_flush;
    logic                      o_pc_redirect;
    logic [ADDR_WIDTH-1:0]     o_redirect_target;
    logic [1:0]                o_state;

    modport master (
        input  i_ic_miss, i_dc_miss, i_ex_valid, i_ex_is_load, i_ex_rw_addr,
               i_dec_uses_rs, i_dec_rs_addr, i_dec_uses_rt, i_dec_rt_addr,
               i_ex_mispredict, i_ex_recovery_target,
        output o_pc_stall, o_pc_flush, o_i2d_stall, o_i2d_flush,
               o_d2e_stall, o_d2e_flush, o_e2m_stall, o_e2m_flush,
               o_m2w_stall, o_m2w_flush, o_pc_redirect, o_redirect_target,
               o_state
    );

    modport slave (
        output i_ic_miss, i_dc_miss, i_ex_valid, i_ex_is_load, i_ex_rw_addr,
               i_dec_uses_rs, i_dec_rs_addr, i_dec_uses_rt, i_dec_rt_addr,
               i_ex_mispredict, i_ex_recovery_target,
        input  o_pc_stall, o_pc_flush, o_i2d_stall, o_i2d_flush,
               o_d2e_stall, o_d2e_flush, o_e2m_stall, o_e2m_flush,
               o_m2w_stall, o_m2w_flush, o_pc_redirect, o_redirect_target,
               o_state
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Central hazard controller: per-stage stall/flush generation, load-use
// detection, and sequencing of a mispredict redirect that arrives during a
// d-cache miss so that it is issued exactly once, when the miss releases.
// Optional macro HAZARD_PERF_COUNTERS_EN adds 32-bit event counters.
module hazard_control_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_control_unit_if.master hc
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [31:0]           o_cnt_dmiss,
    output logic [31:0]           o_cnt_imiss,
    output logic [31:0]           o_cnt_load_use,
    output logic [31:0]           o_cnt_redirect
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DMISS   = 2'd1,
        ST_RPEND   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE     = 3'd0,
        ACT_DMISS    = 3'd1,
        ACT_REDIRECT = 3'd2,
        ACT_LOAD_USE = 3'd3,
        ACT_IMISS    = 3'd4
    } action_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] pend_target_q;
    logic [ADDR_WIDTH-1:0] pend_target_d;
    logic [ADDR_WIDTH-1:0] redirect_target_s;
    action_t               act_s;
    logic                  load_use_s;
    logic [9:0]            sf_s;

    // Load-use: a load in EX writes a non-zero register that decode reads.
    always_comb begin
        load_use_s = hc.i_ex_valid & hc.i_ex_is_load &
                     (hc.i_ex_rw_addr != {REG_ADDR_WIDTH{1'b0}}) &
                     ((hc.i_dec_uses_rs & (hc.i_dec_rs_addr == hc.i_ex_rw_addr)) |
                      (hc.i_dec_uses_rt & (hc.i_dec_rt_addr == hc.i_ex_rw_addr)));
    end

    // Select the action for this cycle and the next FSM state / pending target.
    always_comb begin
        act_s             = ACT_NONE;
        state_d           = ST_RUN;
        pend_target_d     = pend_target_q;
        redirect_target_s = hc.i_ex_recovery_target;
        if (!rst_n) begin
            act_s             = ACT_NONE;
            state_d           = ST_RUN;
            pend_target_d     = {ADDR_WIDTH{1'b0}};
            redirect_target_s = {ADDR_WIDTH{1'b0}};
        end else begin
            case (state_q)
                // RUN and DMISS share one rule set: a DMISS whose miss has
                // dropped is evaluated exactly like RUN in the same cycle.
                ST_RUN, ST_DMISS: begin
                    if (hc.i_dc_miss) begin
                        act_s = ACT_DMISS;
                        if (hc.i_ex_mispredict) begin
                            state_d       = ST_RPEND;
                            pend_target_d = hc.i_ex_recovery_target;
                        end else begin
                            state_d = ST_DMISS;
                        end
                    end else if (hc.i_ex_mispredict) begin
                        act_s = ACT_REDIRECT;
                    end else if (load_use_s) begin
                        act_s = ACT_LOAD_USE;
                    end else if (hc.i_ic_miss) begin
                        act_s = ACT_IMISS;
                    end else begin
                        act_s = ACT_NONE;
                    end
                end
                // Latched target wins; new mispredicts and load-use are
                // wrong-path and therefore ignored here.
                ST_RPEND: begin
                    redirect_target_s = pend_target_q;
                    if (hc.i_dc_miss) begin
                        act_s   = ACT_DMISS;
                        state_d = ST_RPEND;
                    end else begin
                        act_s   = ACT_REDIRECT;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    act_s   = ACT_NONE;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Decode the action into stall/flush pairs, stage order pc..m2w.
    always_comb begin
        sf_s = 10'b00_00_00_00_00;
        case (act_s)
            ACT_DMISS:    sf_s = 10'b10_10_10_10_01;
            ACT_REDIRECT: sf_s = 10'b00_01_01_00_00;
            ACT_LOAD_USE: sf_s = 10'b10_10_01_00_00;
            ACT_IMISS:    sf_s = 10'b10_01_00_00_00;
            default:      sf_s = 10'b00_00_00_00_00;
        endcase
    end

    assign {hc.o_pc_stall,  hc.o_pc_flush,
            hc.o_i2d_stall, hc.o_i2d_flush,
            hc.o_d2e_stall, hc.o_d2e_flush,
            hc.o_e2m_stall, hc.o_e2m_flush,
            hc.o_m2w_stall, hc.o_m2w_flush} = sf_s;
    assign hc.o_pc_redirect     = (act_s == ACT_REDIRECT);
    assign hc.o_redirect_target = redirect_target_s;
    assign hc.o_state           = rst_n ? state_q : ST_RUN;

    // FSM state and pending redirect target, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pend_target_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] cnt_dmiss_q;
    logic [31:0] cnt_imiss_q;
    logic [31:0] cnt_load_use_q;
    logic [31:0] cnt_redirect_q;

    // Event counters: one increment per cycle the matching action is applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_dmiss_q    <= 32'd0;
            cnt_imiss_q    <= 32'd0;
            cnt_load_use_q <= 32'd0;
            cnt_redirect_q <= 32'd0;
        end else begin
            if (act_s == ACT_DMISS)    cnt_dmiss_q    <= cnt_dmiss_q + 32'd1;
            if (act_s == ACT_IMISS)    cnt_imiss_q    <= cnt_imiss_q + 32'd1;
            if (act_s == ACT_LOAD_USE) cnt_load_use_q <= cnt_load_use_q + 32'd1;
            if (act_s == ACT_REDIRECT) cnt_redirect_q <= cnt_redirect_q + 32'd1;
        end
    end

    assign o_cnt_dmiss    = cnt_dmiss_q;
    assign o_cnt_imiss    = cnt_imiss_q;
    assign o_cnt_load_use = cnt_load_use_q;
    assign o_cnt_redirect = cnt_redirect_q;
`endif

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Central hazard controller. Generates the per-stage stall/flush pairs that the pipeline registers (pc, i2d, d2e, e2m, m2w) obey.
- Pipeline registers ignore flush while stalled. This block therefore sequences any flush that arrives during a stall so it takes effect exactly once, when the stall releases.
- Also drives the PC redirect on branch misprediction.
- Sits at top level; its outputs are bound into hazard_control_ifc instances.

Parameters:
- ADDR_WIDTH, 32, width of the PC and recovery target.
- REG_ADDR_WIDTH, 5, architectural register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- i_ic_miss  in  1  i-cache miss in progress (fetch has no valid data)
- i_dc_miss  in  1  d-cache miss in progress (memory stage not ready)
- i_ex_valid  in  1  EX holds a real instruction
- i_ex_is_load  in  1  EX instruction is a load
- i_ex_rw_addr  in  REG_ADDR_WIDTH  EX destination register
- i_dec_uses_rs  in  1  decode reads rs
- i_dec_rs_addr  in  REG_ADDR_WIDTH  decode rs
- i_dec_uses_rt  in  1  decode reads rt
- i_dec_rt_addr  in  REG_ADDR_WIDTH  decode rt
- i_ex_mispredict  in  1  EX resolved branch mispredicted
- i_ex_recovery_target  in  ADDR_WIDTH  correct PC for the mispredict
- o_pc_stall, o_pc_flush  out  1 each  fetch PC register
- o_i2d_stall, o_i2d_flush  out  1 each
- o_d2e_stall, o_d2e_flush  out  1 each
- o_e2m_stall, o_e2m_flush  out  1 each
- o_m2w_stall, o_m2w_flush  out  1 each
- o_pc_redirect  out  1  one-cycle pulse: load o_redirect_target into PC
- o_redirect_target  out  ADDR_WIDTH  redirect PC
- o_state  out  2  FSM state, for debug

Behaviour:
- Reset (rst_n low at posedge): state=RUN, pending target=0. Every stall/flush output=0, o_pc_redirect=0, o_redirect_target=0. Reset mid-miss or mid-pending discards the pending redirect.
- Outputs are combinational from the current state and inputs; the state and pending target are registered.
- Stall monotonicity, always true: a stall at stage k implies stalls at every earlier stage. A flush is never asserted on a register whose stall is asserted.
- load_use = i_ex_valid & i_ex_is_load & i_ex_rw_addr!=0 & ((i_dec_uses_rs & rs==rw) | (i_dec_uses_rt & rt==rw)).
- Priority, highest first:
  1. d-miss: stall pc, i2d, d2e, e2m; flush m2w (bubble into WB).
  2. Redirect: pulse o_pc_redirect; flush i2d and d2e; no stalls. i_ic_miss is ignored this cycle because the wrong-path fetch is abandoned.
  3. load_use: stall pc, i2d; flush d2e.
  4. ic_miss: stall pc; flush i2d.
  5. None of the above: all 0.
- States:
  - RUN
    - i_dc_miss & i_ex_mispredict → latch i_ex_recovery_target; go to REDIRECT_PEND; apply d-miss action.
    - i_dc_miss only → go to DMISS; apply d-miss action.
    - i_ex_mispredict only → apply redirect this cycle using the live target; stay in RUN.
  - DMISS
    - Apply d-miss action while i_dc_miss is high.
    - A mispredict seen here latches the target and moves to REDIRECT_PEND.
    - When i_dc_miss falls, evaluate as RUN in the same cycle; the next state is RUN.
  - REDIRECT_PEND
    - While i_dc_miss is high, apply d-miss action.
    - First cycle i_dc_miss is low: redirect using the latched target; next state RUN.
    - i_ex_mispredict is ignored in this state; the latched target wins.
    - load_use is suppressed because the decode instruction is wrong-path.
- o_redirect_target = latched target while in REDIRECT_PEND, else i_ex_recovery_target.
- Exactly one o_pc_redirect pulse per mispredicted branch.
- A branch held in EX that keeps i_ex_mispredict high across a d-miss must not produce a second pulse. This holds because the redirect flushes d2e.
- Encoding: RUN=0, DMISS=1, REDIRECT_PEND=2; value 3 is illegal and returns to RUN.

Optional Feature:
- Macro: HAZARD_PERF_COUNTERS_EN.
- With the macro defined, the block adds output ports o_cnt_dmiss, o_cnt_imiss, o_cnt_load_use and o_cnt_redirect, each 32 bits.
- Each counter increments on the cycle its action is applied:
  - o_cnt_dmiss, o_cnt_imiss, o_cnt_load_use: once per cycle the action is applied.
  - o_cnt_redirect: once per redirect pulse.
- Counters are zeroed by reset and wrap modulo 2^32.
- Without the macro, these ports and their registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset with all inputs high → every output 0, o_state=0. After release with i_dc_miss=1: pc/i2d/d2e/e2m stall=1, m2w_flush=1, o_state=1.
- EX load writes r5; decode uses rs=r5 → pc and i2d stall, d2e flush, for 1 cycle. The same case with rw=r0 → no stall.
- i_ex_mispredict with target 0x0040_0100 and i_ic_miss=1, no d-miss → o_pc_redirect pulses for 1 cycle with target 0x0040_0100; i2d and d2e flush; pc_stall=0.
- i_dc_miss and mispredict (target 0x0040_0200) together for 4 cycles, while the live target input changes to 0xDEAD_BEEF → state 2, no redirect. When the d-miss drops: exactly one redirect pulse with target 0x0040_0200, then state 0.
- i_ic_miss alone → pc stall, i2d flush. Adding load_use the same cycle → load_use action (i2d stalled, d2e flushed).
- Reset asserted while in REDIRECT_PEND → no redirect pulse ever issued; state 0. With HAZARD_PERF_COUNTERS_EN, 3 d-miss cycles followed by reset → o_cnt_dmiss reads 3, then 0.
